// File: rtl/cone_sweep_driver.sv
// Exhaustive stimulus sweep for one combinational cone: applies every input vector to a
// golden and a fault-injected copy, then counts output mismatches and records the first one.
module cone_sweep_driver #(
  parameter int N_IN       = 9,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_o,
  input  logic            golden_i,
  input  logic            faulty_i,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC);
  localparam logic [N_IN-1:0] VEC_MAX     = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = (N_IN)'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN+1)'(1);
  // With no settle time a freshly loaded vector is sampled on the very next edge.
  localparam state_e          LOAD_STATE  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  state_e          r_state;
  logic [N_IN-1:0] r_vec;
  logic [3:0]      r_cnt;
  logic [N_IN:0]   r_mcnt;
  logic            r_fail_seen;
  logic [N_IN-1:0] r_first_fail;

  state_e          w_state_next;
  logic [N_IN-1:0] w_vec_next;
  logic [3:0]      w_cnt_next;
  logic [N_IN:0]   w_mcnt_next;
  logic            w_fail_seen_next;
  logic [N_IN-1:0] w_first_fail_next;
  logic [3:0]      w_cnt_inc;
  logic            w_mismatch;

  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_mismatch = golden_i ^ faulty_i;

  always_comb begin
    w_state_next      = r_state;
    w_vec_next        = r_vec;
    w_cnt_next        = r_cnt;
    w_mcnt_next       = r_mcnt;
    w_fail_seen_next  = r_fail_seen;
    w_first_fail_next = r_first_fail;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next      = LOAD_STATE;
          w_vec_next        = '0;
          w_cnt_next        = 4'd0;
          w_mcnt_next       = '0;
          w_fail_seen_next  = 1'b0;
          w_first_fail_next = '0;
        end
      end
      SETTLE: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc == SETTLE_LAST) begin
          w_state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (w_mismatch) begin
          w_mcnt_next = r_mcnt + CNT_ONE;
          // Ascending sweep, so the first mismatch seen is also the lowest failing vector.
          if (!r_fail_seen) begin
            w_fail_seen_next  = 1'b1;
            w_first_fail_next = r_vec;
          end
        end
        if (r_vec == VEC_MAX) begin
          w_state_next = DONE;
        end else begin
          w_vec_next   = r_vec + VEC_ONE;
          w_cnt_next   = 4'd0;
          w_state_next = LOAD_STATE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_cnt        <= 4'd0;
      r_mcnt       <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vec        <= w_vec_next;
      r_cnt        <= w_cnt_next;
      r_mcnt       <= w_mcnt_next;
      r_fail_seen  <= w_fail_seen_next;
      r_first_fail <= w_first_fail_next;
    end
  end

  assign vec_o          = r_vec;
  assign busy           = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done           = (r_state == DONE);
  assign mismatch_cnt   = r_mcnt;
  assign fail_seen      = r_fail_seen;
  assign first_fail_vec = r_first_fail;

endmodule

// File: tb/tb_cone_sweep_driver.sv
// Directed bench for cone_sweep_driver: a behavioural cone pair drives both copies, and
// per-sweep expectations from a reference model are queued then checked when done rises.
module tb_cone_sweep_driver;

  localparam int N = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [N-1:0] vec_a, vec_b, ffv_a, ffv_b;
  logic [N:0]   mc_a, mc_b;
  logic         g_a, f_a, g_b, f_b;
  logic         busy_a, busy_b, done_a, done_b, fs_a, fs_b;

  int mode  = 0;
  int sel   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int cycles;
    int mcnt;
    int fs;
    int ffv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cone_sweep_driver #(.N_IN(N), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_o(vec_a),
    .golden_i(g_a), .faulty_i(f_a), .busy(busy_a), .done(done_a),
    .mismatch_cnt(mc_a), .fail_seen(fs_a), .first_fail_vec(ffv_a)
  );

  cone_sweep_driver #(.N_IN(N), .SETTLE_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_o(vec_b),
    .golden_i(g_b), .faulty_i(f_b), .busy(busy_b), .done(done_b),
    .mismatch_cnt(mc_b), .fail_seen(fs_b), .first_fail_vec(ffv_b)
  );

  function automatic logic gold_f(input int m, input int v);
    logic [8:0] x;
    x = v[8:0];
    case (m)
      0:       return ^x;
      1:       return x[0];
      2:       return x[1];
      default: return x[2] ^ x[5];
    endcase
  endfunction

  function automatic logic faulty_f(input int m, input int v);
    logic       g;
    logic [8:0] x;
    x = v[8:0];
    g = gold_f(m, v);
    case (m)
      0:       return g;
      1:       return 1'b0;
      2:       return ~g;
      default: return (x == 9'h1FF) ? ~g : g;
    endcase
  endfunction

  always_comb begin
    g_a = gold_f(mode, int'(vec_a));
    f_a = faulty_f(mode, int'(vec_a));
    g_b = gold_f(mode, int'(vec_b));
    f_b = faulty_f(mode, int'(vec_b));
  end

  logic [N-1:0] s_vec, s_ffv;
  logic [N:0]   s_mc;
  logic         s_busy, s_done, s_fs;
  always_comb begin
    s_vec  = (sel == 0) ? vec_a  : vec_b;
    s_ffv  = (sel == 0) ? ffv_a  : ffv_b;
    s_mc   = (sel == 0) ? mc_a   : mc_b;
    s_busy = (sel == 0) ? busy_a : busy_b;
    s_done = (sel == 0) ? done_a : done_b;
    s_fs   = (sel == 0) ? fs_a   : fs_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "/vec"},  32'(s_vec),  32'h0);
    chk({tag, "/busy"}, 32'(s_busy), 32'h0);
    chk({tag, "/done"}, 32'(s_done), 32'h0);
    chk({tag, "/mcnt"}, 32'(s_mc),   32'h0);
    chk({tag, "/fs"},   32'(s_fs),   32'h0);
    chk({tag, "/ffv"},  32'(s_ffv),  32'h0);
  endtask

  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // inj >= 0: pulse start again once vec_o reaches that value mid-sweep.
  task automatic run_sweep(input int s, input int m, input int inj, input string tag);
    exp_t e;
    int   cyc;
    bit   injd;
    sel  = s;
    mode = m;
    e.cycles = 512 * ((s == 0) ? 3 : 1);
    e.mcnt = 0;
    e.fs   = 0;
    e.ffv  = 0;
    for (int v = 0; v < 512; v++) begin
      if (gold_f(m, v) !== faulty_f(m, v)) begin
        if (e.fs == 0) begin
          e.fs  = 1;
          e.ffv = v;
        end
        e.mcnt++;
      end
    end
    sb.push_back(e);
    pulse_start(s);
    chk({tag, "/busy_at_start"}, 32'(s_busy), 32'h1);
    chk({tag, "/done_at_start"}, 32'(s_done), 32'h0);
    chk({tag, "/vec_at_start"},  32'(s_vec),  32'h0);
    chk({tag, "/mcnt_at_start"}, 32'(s_mc),   32'h0);
    chk({tag, "/fs_at_start"},   32'(s_fs),   32'h0);
    cyc  = 0;
    injd = 1'b0;
    while (s_done !== 1'b1 && cyc < e.cycles + 64) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
      if (inj >= 0 && !injd && int'(s_vec) == inj) begin
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        injd = 1'b1;
      end
    end
    e = sb.pop_front();
    chk({tag, "/cycles"}, 32'(cyc),    32'(e.cycles));
    chk({tag, "/mcnt"},   32'(s_mc),   32'(e.mcnt));
    chk({tag, "/fs"},     32'(s_fs),   32'(e.fs));
    chk({tag, "/ffv"},    32'(s_ffv),  32'(e.ffv));
    chk({tag, "/vec"},    32'(s_vec),  32'h1FF);
    chk({tag, "/busy"},   32'(s_busy), 32'h0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 0;
    chk_reset_state("reset_a");
    sel = 1;
    chk_reset_state("reset_b");

    run_sweep(0, 0, -1, "tie");
    run_sweep(0, 1, -1, "lsb");
    run_sweep(0, 2, -1, "inv");
    run_sweep(0, 3, -1, "top");

    // DONE must hold its results and the all-ones vector without wrapping.
    repeat (5) @(posedge clk);
    #1;
    chk("top_hold/vec",  32'(s_vec),  32'h1FF);
    chk("top_hold/done", 32'(s_done), 32'h1);
    chk("top_hold/mcnt", 32'(s_mc),   32'h1);

    // Abort mid-sweep with reset, then confirm a fresh sweep.
    sel  = 0;
    mode = 1;
    pulse_start(0);
    cyc = 0;
    while (vec_a !== 9'h080 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort/reached_080", 32'(vec_a), 32'h080);
    chk("abort/fs_before",   32'(fs_a),  32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("abort");
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle/busy", 32'(busy_a), 32'h0);
    chk("abort_idle/vec",  32'(vec_a),  32'h0);
    run_sweep(0, 1, -1, "after_abort");

    run_sweep(0, 2, 16, "busy_start");
    run_sweep(0, 0, -1, "restart");

    run_sweep(1, 1, -1, "s0_lsb");
    run_sweep(1, 3, -1, "s0_top");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cone_sweep_driver.md
Name: cone_sweep_driver

Overview:
- Sequential stimulus/observer block that sits on the other end of a combinational cone under SEE analysis.
- Drives every input combination (0 to 2^N_IN-1) into a fault-free copy and a fault-injected copy of the same cone.
- Waits a fixed settle time per vector, then compares the two cone outputs.
- Reports the mismatch count and the first failing vector, which gives the error-propagation figure for that cone and fault site.

Parameters:
- N_IN, 9, number of cone inputs (vector width); legal 1..16.
- SETTLE_CYC, 2, idle cycles between applying a vector and sampling the outputs; legal 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- vec_o  output  N_IN  current stimulus vector; bit k drives cone input i_k_ on both copies.
- golden_i  input  1  output of the fault-free cone.
- faulty_i  input  1  output of the fault-injected cone.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE until the next start or rst.
- mismatch_cnt  output  N_IN+1  number of vectors where golden_i != faulty_i.
- fail_seen  output  1  at least one mismatch recorded this sweep.
- first_fail_vec  output  N_IN  lowest vector value that mismatched; valid when fail_seen=1.

Behaviour:
- Reset (sync, on the cycle rst=1):
  - state=IDLE, vec_o=0, busy=0, done=0, mismatch_cnt=0, fail_seen=0, first_fail_vec=0, settle counter=0.
  - rst overrides start and aborts a sweep in progress; partial results are discarded.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> next cycle SETTLE, vec_o=0, busy=1.
  - Counters and fail_seen are cleared on the same edge.
- SETTLE:
  - Counter increments each cycle.
  - When counter reaches SETTLE_CYC -> SAMPLE.
  - SETTLE_CYC=0 goes straight from the vector-load edge to SAMPLE.
- SAMPLE (exactly one cycle; golden_i/faulty_i are registered-compared on this edge):
  - Mismatch: mismatch_cnt += 1. If fail_seen=0, set first_fail_vec=vec_o and fail_seen=1.
  - If vec_o != all-ones: vec_o += 1, counter=0, -> SETTLE.
  - If vec_o == all-ones: -> DONE, busy=0, done=1; vec_o holds all-ones. No wrap to 0 is permitted.
- DONE:
  - Outputs hold.
  - start=1 -> clears results and restarts exactly as from IDLE; done drops the same edge busy rises.
- start while busy=1 is ignored; it neither restarts nor extends the sweep.
- vec_o changes only on the SAMPLE->SETTLE edge or the start edge. It is stable for SETTLE_CYC+1 cycles per vector.
- Latency:
  - Each vector occupies SETTLE_CYC+1 cycles (SETTLE_CYC in SETTLE plus 1 in SAMPLE).
  - Full sweep is 2^N_IN*(SETTLE_CYC+1) cycles from the start edge to the done rising edge.
  - Default: 512*3 = 1536 cycles.
- Widths:
  - mismatch_cnt is N_IN+1 bits and cannot overflow (max 2^N_IN).
  - first_fail_vec is the lowest failing vector, since the sweep is ascending.
- golden_i/faulty_i are only looked at in SAMPLE; values in other states are don't-care.
- busy and done are never both 1.

Test Plan:
- Tie faulty_i=golden_i, pulse start -> done rises exactly 1536 cycles after the start edge; mismatch_cnt=0, fail_seen=0, first_fail_vec=0.
- golden_i=vec_o[0], faulty_i=0 -> mismatch_cnt=256, fail_seen=1, first_fail_vec=9'h001.
- faulty_i=~golden_i -> mismatch_cnt=512 (full width, no overflow), first_fail_vec=9'h000.
- faulty_i differs only when vec_o=9'h1FF -> mismatch_cnt=1, first_fail_vec=9'h1FF; done rises the edge after that SAMPLE; vec_o holds 9'h1FF.
- Assert rst when vec_o=9'h080 mid-sweep -> next cycle all outputs are at reset values and state is IDLE. A later start sweeps from 0 with a fresh count.
- Pulse start at vec_o=9'h010 (busy) -> ignored, sweep length unchanged. Pulse start in DONE -> results cleared and a new 1536-cycle sweep runs; SETTLE_CYC=0 variant completes in 512 cycles.
